// File: rtl/instr_batch_packer_pkg.sv
// Shared types and constants for the instruction batch packer.
package instr_batch_packer_pkg;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned BUNDLE_W  = 192;
  localparam int unsigned QTY_W     = 3;
  localparam int unsigned MIN_BATCH = 2;
  localparam int unsigned NUM_SLOTS = BUNDLE_W / INSTR_W;
  localparam int unsigned WW_W      = 11;

  typedef enum logic {FILL, EMIT} state_t;

  typedef logic [NUM_SLOTS-1:0][INSTR_W-1:0] bundle_t;
endpackage

// File: rtl/instr_batch_packer_if.sv
// Instruction stream in, bundle write strobe out; master drives the stream.
interface instr_batch_packer_if;
  import instr_batch_packer_pkg::*;

  logic                in_valid;
  logic [INSTR_W-1:0]  in_instr;
  logic                in_ready;
  logic                flush;
  logic                write_enable;
  logic [BUNDLE_W-1:0] instructions;
  logic [QTY_W-1:0]    quantity;
  logic [WW_W-1:0]     words_written;
  logic                full;
  logic                drop;

  modport master (
    output in_valid, in_instr, flush,
    input  in_ready, write_enable, instructions, quantity, words_written, full, drop
  );

  modport slave (
    input  in_valid, in_instr, flush,
    output in_ready, write_enable, instructions, quantity, words_written, full, drop
  );
endinterface

// File: rtl/instr_batch_packer_capacity_tracker.sv
// Mirrors the RAM writer cursor and derives the capacity/full terms.
module packer_capacity_tracker
  import instr_batch_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             emit,
  input  logic [QTY_W-1:0] quantity,
  input  logic [QTY_W-1:0] pending,
  output logic [WW_W-1:0]  words_written,
  output logic             full,
  output logic             room,
  output logic             one_left
);
  localparam int unsigned XW = WW_W + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);

  logic [XW-1:0] ww_x;
  logic [XW-1:0] committed;
  logic [XW-1:0] sum;

  assign ww_x      = {1'b0, words_written};
  assign committed = ww_x + XW'(pending);
  assign sum       = ww_x + XW'(quantity);

  assign full     = (committed == DEPTH_X);
  assign room     = (committed < DEPTH_X);
  assign one_left = (ww_x == XW'(DEPTH - 1));

  // Count is committed on the edge that ends EMIT; saturate at capacity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_written <= '0;
    end else if (emit) begin
      words_written <= (sum >= DEPTH_X) ? DEPTH_X[WW_W-1:0] : sum[WW_W-1:0];
    end
  end
endmodule

// File: rtl/instr_batch_packer.sv
// Packs a 32-bit instruction stream into 2..6-word bundles for the RAM writer.
// Optional idle auto-flush enabled by defining PACKER_TIMEOUT_EN.
module instr_batch_packer
  import instr_batch_packer_pkg::*;
#(
  parameter int unsigned        MAX_BATCH = 6,
  parameter int unsigned        DEPTH     = 1024,
  parameter logic [INSTR_W-1:0] PAD_WORD  = 32'h0000_0000
`ifdef PACKER_TIMEOUT_EN
  , parameter int unsigned      TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_batch_packer_if.slave  bus
);
  localparam logic [QTY_W-1:0] MAXQ = QTY_W'(MAX_BATCH);
  localparam logic [QTY_W-1:0] MINQ = QTY_W'(MIN_BATCH);

  state_t           state_q, state_d;
  logic [QTY_W-1:0] count_q, count_d, cnt_acc;
  bundle_t          slots_q, slots_d, slots_acc;
  bundle_t          bundle_q, bundle_d;
  logic [QTY_W-1:0] qty_q, qty_d, emit_qty;
  logic             we_q, we_d;
  logic             drop_q, drop_d;
  logic             flush_pend_q, flush_pend_d;
  logic             emit_now;
  logic             accept, flush_req, timeout_fire;
  logic             room, one_left;

  packer_capacity_tracker #(
    .DEPTH (DEPTH)
  ) u_capacity (
    .clk           (clk),
    .rst_n         (rst_n),
    .emit          (state_q == EMIT),
    .quantity      (qty_q),
    .pending       (count_q),
    .words_written (bus.words_written),
    .full          (bus.full),
    .room          (room),
    .one_left      (one_left)
  );

  assign bus.in_ready     = (state_q == FILL) && room;
  assign bus.write_enable = we_q;
  assign bus.instructions = bundle_q;
  assign bus.quantity     = qty_q;
  assign bus.drop         = drop_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign flush_req = bus.flush || flush_pend_q || timeout_fire;

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;

  // Cleared whenever nothing is pending so a stale count cannot fire on the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (accept || state_q == EMIT || count_q == '0) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign timeout_fire = (state_q == FILL) && (count_q != '0) &&
                        (idle_q == IDLE_W'(TIMEOUT_CYCLES));
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    slots_acc = slots_q;
    if (accept && count_q < QTY_W'(NUM_SLOTS)) begin
      slots_acc[count_q] = bus.in_instr;
    end
    cnt_acc = count_q + QTY_W'(accept);

    state_d      = state_q;
    count_d      = count_q;
    slots_d      = slots_q;
    bundle_d     = bundle_q;
    qty_d        = qty_q;
    we_d         = 1'b0;
    drop_d       = 1'b0;
    flush_pend_d = flush_pend_q;
    emit_now     = 1'b0;
    emit_qty     = '0;

    unique case (state_q)
      FILL: begin
        flush_pend_d = 1'b0;
        slots_d      = slots_acc;
        count_d      = cnt_acc;
        // A word completing the batch absorbs any concurrent flush.
        if (cnt_acc == MAXQ) begin
          emit_now = 1'b1;
          emit_qty = MAXQ;
        end else if (flush_req) begin
          if (cnt_acc == QTY_W'(1)) begin
            if (one_left) begin
              drop_d  = 1'b1;
              slots_d = '0;
              count_d = '0;
            end else begin
              slots_acc[1] = PAD_WORD;
              emit_now     = 1'b1;
              emit_qty     = MINQ;
            end
          end else if (cnt_acc >= MINQ) begin
            emit_now = 1'b1;
            emit_qty = cnt_acc;
          end
        end
      end
      EMIT: begin
        state_d = FILL;
        count_d = '0;
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
      end
    endcase

    // count carries the emitted quantity through EMIT so full stays continuous.
    if (emit_now) begin
      state_d  = EMIT;
      we_d     = 1'b1;
      qty_d    = emit_qty;
      bundle_d = slots_acc;
      slots_d  = '0;
      count_d  = emit_qty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      count_q      <= '0;
      slots_q      <= '0;
      bundle_q     <= '0;
      qty_q        <= '0;
      we_q         <= 1'b0;
      drop_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      slots_q      <= slots_d;
      bundle_q     <= bundle_d;
      qty_q        <= qty_d;
      we_q         <= we_d;
      drop_q       <= drop_d;
      flush_pend_q <= flush_pend_d;
    end
  end
endmodule
